cplx_round_clip: RTL
====================

CPLX_ROUND_CLIP -- requirements
Module: cplx_round_clip

Interface
- REQ-001: WIDTH_IN, 48: signed width of each I/Q input component; matches the product width of the upstream real-by-complex multiplier.
- REQ-002: WIDTH_OUT, 16: signed width of each I/Q output component; WIDTH_OUT SHALL be at most WIDTH_IN-FRAC_BITS.
- REQ-003: FRAC_BITS, 15: LSBs removed by rounding; range 0..WIDTH_IN-2.
- REQ-004: clk  in  1  sole clock; all logic is on its rising edge.
- REQ-005: reset_n  in  1  asynchronous, active-low reset.
- REQ-006: i_tdata  in  2*WIDTH_IN  complex product; I in the upper half, Q in the lower half.
- REQ-007: i_tlast  in  1  end of packet.
- REQ-008: i_tvalid  in  1  input valid.
- REQ-009: i_tready  out  1  input ready.
- REQ-010: o_tdata  out  2*WIDTH_OUT  rounded, clipped sample; I in the upper half, Q in the lower half.
- REQ-011: o_tlast  out  1  end of packet, aligned with o_tdata.
- REQ-012: o_tvalid  out  1  output valid.
- REQ-013: o_tready  in  1  output ready.
- REQ-014: clear  in  1  synchronous clear of the sticky flag (and of the counter, when compiled in).
- REQ-015: clip_flag  out  1  sticky flag; set when any component has clipped since the last reset or clear.

Function
- REQ-016: The block SHALL have two register stages. S1 holds the rounded value at WIDTH_IN-FRAC_BITS+1 bits plus tlast. S2 holds the clipped value plus tlast.
- REQ-017: Rounding SHALL be round-half-up per component: (x + 2^(FRAC_BITS-1)) >>> FRAC_BITS, computed one bit wider so the add cannot overflow.
- REQ-018: With FRAC_BITS=0, rounding SHALL pass the value through unchanged.
- REQ-019: Clipping SHALL saturate each component to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1].
- REQ-020: I and Q SHALL be processed independently.
- REQ-021: A beat is transferred when valid and ready are both high in the same cycle; tdata and tlast are held stable while valid is high and ready is low.
- REQ-022: S2 SHALL load when S1 is valid and (S2 is empty or o_tready is high).
- REQ-023: S1 SHALL load when i_tvalid is high and (S1 is empty or S1 is advancing into S2 in that cycle).
- REQ-024: i_tready SHALL be asserted when S1 is empty or S1 is advancing; it SHALL be combinational from register state and o_tready only.
- REQ-025: Latency SHALL be 2 cycles from input transfer to o_tvalid.
- REQ-026: With o_tready held high, throughput SHALL be 1 beat per cycle, with no bubbles.
- REQ-027: When o_tready is low, the pipeline SHALL fill both stages and then hold i_tready low. No beat is dropped or duplicated.
- REQ-028: tlast SHALL travel with its own beat.
- REQ-029: clip_flag SHALL set in the cycle after S2 loads a beat in which either component saturated.
- REQ-030: If clear and a clipping load occur in the same cycle, the set SHALL win.

Reset
- REQ-031: While reset_n is low, o_tvalid, o_tlast, o_tdata, clip_flag and both stage-valid bits SHALL be 0.
- REQ-032: While reset_n is low, i_tready SHALL be 0.
- REQ-033: Reset asserted mid-packet SHALL discard all in-flight beats.
- REQ-034: The first cycle after reset_n deasserts SHALL present i_tready=1 and o_tvalid=0.

Configuration
- REQ-035: When macro CPLX_ROUND_CLIP_CNT_EN is defined, the block SHALL add output clip_cnt  out  32.
- REQ-036: clip_cnt SHALL increment by 1 for each S2 load with any clipped component, saturate at 0xFFFFFFFF, clear on clear (an increment in the same cycle wins, yielding 1), and reset to 0.
- REQ-037: Without CPLX_ROUND_CLIP_CNT_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Verification (defaults: WIDTH_IN=48, WIDTH_OUT=16, FRAC_BITS=15)
- REQ-038: Rounding, o_tready=1: I=16384, Q=-16384 -> o_tdata I=0x0001, Q=0x0000, 2 cycles later; I=-16385 -> 0xFFFF; clip_flag stays 0.
- REQ-039: Clip: I=2^30, Q=-2^31 -> I=0x7FFF, Q=0x8000; clip_flag=1 on the next cycle; clip_cnt=1 with the macro; clear pulse -> flag 0.
- REQ-040: Backpressure: stream 100 incrementing beats with tlast on every 10th beat; o_tready random at 50% -> output is identical, in order, with tlast on beats 10, 20, ...; i_tready falls after 2 stalled beats.
- REQ-041: Full rate: i_tvalid=1 and o_tready=1 for 64 cycles -> 64 consecutive output beats with no gap.
- REQ-042: Reset mid-packet: reset_n low for 1 cycle with both stages full -> o_tvalid=0 immediately; the next input emerges 2 cycles after its transfer.
- REQ-043: Counter saturation, with the macro: force clip_cnt to 0xFFFFFFFE, send 3 clipping beats -> 0xFFFFFFFF holds.

Source files
------------

// File: rtl/cplx_round_clip.sv
// Complex round-half-up and saturate, two-stage valid/ready pipeline.
// Optional clip counter port clip_cnt when CPLX_ROUND_CLIP_CNT_EN is defined.
module cplx_round_clip #(
  parameter int WIDTH_IN  = 48,
  parameter int WIDTH_OUT = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2*WIDTH_IN-1:0]    i_tdata,
  input  logic                     i_tlast,
  input  logic                     i_tvalid,
  output logic                     i_tready,
  output logic [2*WIDTH_OUT-1:0]   o_tdata,
  output logic                     o_tlast,
  output logic                     o_tvalid,
  input  logic                     o_tready,
  input  logic                     clear,
  output logic                     clip_flag
`ifdef CPLX_ROUND_CLIP_CNT_EN
  ,
  output logic [31:0]              clip_cnt
`endif
);

  localparam int RW = WIDTH_IN - FRAC_BITS + 1;
  localparam int SH = (FRAC_BITS == 0) ? 0 : FRAC_BITS - 1;
  localparam logic [WIDTH_IN:0] HALF =
    (FRAC_BITS == 0) ? '0 : ((WIDTH_IN+1)'(1) << SH);

  typedef struct packed {
    logic          last;
    logic [RW-1:0] i;
    logic [RW-1:0] q;
  } s1_t;

  // Extra top bit keeps the half-LSB add from overflowing.
  function automatic logic [RW-1:0] rnd(
    input logic [WIDTH_IN-1:0] x
  );
    logic [WIDTH_IN:0] s;
    s = {x[WIDTH_IN-1], x} + HALF;
    return s[WIDTH_IN:FRAC_BITS];
  endfunction

  // Returns {clipped, value}; in range when all high bits agree.
  function automatic logic [WIDTH_OUT:0] sat(
    input logic [RW-1:0] v
  );
    logic [RW-WIDTH_OUT:0] hi;
    hi = v[RW-1:WIDTH_OUT-1];
    if ((&hi) || !(|hi))
      return {1'b0, v[WIDTH_OUT-1:0]};
    else if (v[RW-1])
      return {2'b11, {(WIDTH_OUT-1){1'b0}}};
    else
      return {2'b10, {(WIDTH_OUT-1){1'b1}}};
  endfunction

  s1_t                s1;
  logic               s1_valid;
  logic               s2_valid;
  logic               s1_load;
  logic               s2_load;
  logic               clip_ld;
  logic [WIDTH_OUT:0] sat_i;
  logic [WIDTH_OUT:0] sat_q;

  always_comb begin
    sat_i    = sat(s1.i);
    sat_q    = sat(s1.q);
    s2_load  = s1_valid && (!s2_valid || o_tready);
    i_tready = reset_n && (!s1_valid || s2_load);
    s1_load  = i_tvalid && i_tready;
    clip_ld  = s2_load && (sat_i[WIDTH_OUT] || sat_q[WIDTH_OUT]);
  end

  assign o_tvalid = s2_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1.last  <= i_tlast;
      s1.i     <= rnd(i_tdata[2*WIDTH_IN-1:WIDTH_IN]);
      s1.q     <= rnd(i_tdata[WIDTH_IN-1:0]);
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      o_tdata  <= {sat_i[WIDTH_OUT-1:0],
                   sat_q[WIDTH_OUT-1:0]};
      o_tlast  <= s1.last;
    end else if (o_tready) begin
      s2_valid <= 1'b0;
    end
  end

  // A clip landing in the same cycle as clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      clip_flag <= 1'b0;
    else if (clip_ld)
      clip_flag <= 1'b1;
    else if (clear)
      clip_flag <= 1'b0;
  end

`ifdef CPLX_ROUND_CLIP_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      clip_cnt <= '0;
    else if (clip_ld) begin
      if (clear)
        clip_cnt <= 32'd1;
      else if (clip_cnt != '1)
        clip_cnt <= clip_cnt + 32'd1;
    end else if (clear)
      clip_cnt <= '0;
  end
`endif

endmodule
